// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
// Holds the FSM state encoding, row-count and settle-counter width functions.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic int N_ROWS(input int n);
      return 1 << n;
   endfunction

   // A zero-cycle settle still needs a 1-bit counter to elaborate.
   function automatic int settle_w(input int s);
      return (s < 1) ? 1 : $clog2(s + 1);
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter timing how long a row vector is held before sampling.
// Loaded on entry to SETTLE; o_expire marks the last settle cycle.
module tt_settle_timer
   import tt_sweep_pkg::*;
#(
   parameter int SETTLE = 1,
   parameter int W      = settle_w(SETTLE)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [W-1:0] LOAD = W'(SETTLE - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= LOAD;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps evaluator inputs through every row, samples SoP/PoS, flags mismatches.
// Optional TT_STOP_ON_MISMATCH_EN ends the sweep at the first mismatching row.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  s_sop,
   input  logic                  s_pos,
   output logic [N_IN-1:0]       vec,
   output logic                  busy,
   output logic                  done,
   output logic [(1<<N_IN)-1:0]  tt_sop,
   output logic [(1<<N_IN)-1:0]  tt_pos,
   output logic [(1<<N_IN)-1:0]  mm_mask,
   output logic [N_IN:0]         mm_cnt,
   output logic [N_IN-1:0]       mm_first
);

   localparam int ROWS = N_ROWS(N_IN);
   localparam logic [N_IN:0] LAST_ROW = (N_IN+1)'(ROWS - 1);
   localparam logic [N_IN:0] CNT_MAX  = (N_IN+1)'(ROWS);
   localparam state_t ST_ROW = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

   state_t              r_state;
   logic [N_IN:0]       r_row;
   logic [N_IN-1:0]     r_vec;
   logic                r_busy;
   logic                r_done;
   logic [ROWS-1:0]     r_tt_sop;
   logic [ROWS-1:0]     r_tt_pos;
   logic [ROWS-1:0]     r_mm_mask;
   logic [N_IN:0]       r_mm_cnt;
   logic [N_IN-1:0]     r_mm_first;

   logic                w_mis;
   logic                w_stop;
   logic                w_last;
   logic                w_end;
   logic                w_load;
   logic                w_expire;
   logic [N_IN-1:0]     w_idx;

   assign w_mis  = s_sop ^ s_pos;
   assign w_idx  = r_row[N_IN-1:0];
   assign w_last = (r_row == LAST_ROW);

`ifdef TT_STOP_ON_MISMATCH_EN
   assign w_stop = w_mis;
`else
   assign w_stop = 1'b0;
`endif

   assign w_end  = w_last | w_stop;
   assign w_load = ((r_state == ST_IDLE) && start) ||
                   ((r_state == ST_SAMPLE) && !w_end);

   tt_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_en     (r_state == ST_SETTLE),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_row      <= '0;
         r_vec      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_tt_sop   <= '0;
         r_tt_pos   <= '0;
         r_mm_mask  <= '0;
         r_mm_cnt   <= '0;
         r_mm_first <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_row      <= '0;
                  r_vec      <= '0;
                  r_tt_sop   <= '0;
                  r_tt_pos   <= '0;
                  r_mm_mask  <= '0;
                  r_mm_cnt   <= '0;
                  r_mm_first <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_ROW;
               end
            end
            ST_SETTLE: begin
               if (w_expire) r_state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               r_tt_sop[w_idx] <= s_sop;
               r_tt_pos[w_idx] <= s_pos;
               if (w_mis) begin
                  r_mm_mask[w_idx] <= 1'b1;
                  if (r_mm_cnt != CNT_MAX) r_mm_cnt <= r_mm_cnt + (N_IN+1)'(1);
                  if (r_mm_cnt == '0) r_mm_first <= w_idx;
               end
               if (w_end) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
               end else begin
                  r_row   <= r_row + (N_IN+1)'(1);
                  r_vec   <= r_vec + N_IN'(1);
                  r_state <= ST_ROW;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign vec      = r_vec;
   assign busy     = r_busy;
   assign done     = r_done;
   assign tt_sop   = r_tt_sop;
   assign tt_pos   = r_tt_pos;
   assign mm_mask  = r_mm_mask;
   assign mm_cnt   = r_mm_cnt;
   assign mm_first = r_mm_first;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: default instance plus a SETTLE=3 one.
// Stimulus queues expected sweep results; monitors compare on each done pulse.
module tb_truth_table_sweeper;

   typedef struct {
      string       name;
      logic [15:0] sop;
      logic [15:0] pos;
      logic [15:0] mask;
      logic [4:0]  cnt;
      logic [3:0]  first;
      logic [3:0]  vec;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start3 = 1'b0;
   logic        s_sop, s_pos, s_sop3, s_pos3;
   logic [3:0]  vec, vec3;
   logic        busy, done, busy3, done3;
   logic [15:0] tt_sop, tt_pos, mm_mask;
   logic [15:0] tt_sop3, tt_pos3, mm_mask3;
   logic [4:0]  mm_cnt, mm_cnt3;
   logic [3:0]  mm_first, mm_first3;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mode = 0;
   logic [15:0] guia;
   exp_t        q[$];
   exp_t        q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign guia   = 16'hE5AB;
   assign s_sop  = guia[vec];
   assign s_pos  = (mode == 1 && vec == 4'd9) ? 1'b1 : guia[vec];
   assign s_sop3 = ^vec3;
   assign s_pos3 = ^vec3;

   truth_table_sweeper dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .s_sop(s_sop), .s_pos(s_pos), .vec(vec),
      .busy(busy), .done(done),
      .tt_sop(tt_sop), .tt_pos(tt_pos), .mm_mask(mm_mask),
      .mm_cnt(mm_cnt), .mm_first(mm_first)
   );

   truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .s_sop(s_sop3), .s_pos(s_pos3), .vec(vec3),
      .busy(busy3), .done(done3),
      .tt_sop(tt_sop3), .tt_pos(tt_pos3), .mm_mask(mm_mask3),
      .mm_cnt(mm_cnt3), .mm_first(mm_first3)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp(input exp_t e, input logic [15:0] a_sop,
                      input logic [15:0] a_pos, input logic [15:0] a_mask,
                      input logic [4:0] a_cnt, input logic [3:0] a_first,
                      input logic [3:0] a_vec, input logic a_busy);
      chk({e.name, "_lat"},   cyc - e.t0, e.lat);
      chk({e.name, "_sop"},   a_sop,   e.sop);
      chk({e.name, "_pos"},   a_pos,   e.pos);
      chk({e.name, "_mask"},  a_mask,  e.mask);
      chk({e.name, "_cnt"},   a_cnt,   e.cnt);
      chk({e.name, "_first"}, a_first, e.first);
      chk({e.name, "_vec"},   a_vec,   e.vec);
      chk({e.name, "_busy"},  a_busy,  1'b0);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done at cycle %0d: got done=1 expected 0", cyc);
         end else begin
            cmp(q.pop_front(), tt_sop, tt_pos, mm_mask,
                mm_cnt, mm_first, vec, busy);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done3) begin
         if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done3 at cycle %0d: got done=1 expected 0", cyc);
         end else begin
            cmp(q3.pop_front(), tt_sop3, tt_pos3, mm_mask3,
                mm_cnt3, mm_first3, vec3, busy3);
         end
      end
   end

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done", nm);
         q.delete();
      end
   endtask

   task automatic run(input int m, input exp_t e, input bit perturb);
      @(negedge clk);
      mode = m;
      e.t0 = cyc;
      q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({e.name, "_vec0"}, vec, 4'd0);
      chk({e.name, "_busy1"}, busy, 1'b1);
      if (perturb) begin
         repeat (4) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (14) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_drain(e.name);
      repeat (5) @(negedge clk);
   endtask

   function automatic exp_t mk(input string nm, input logic [15:0] s,
                               input logic [15:0] p, input logic [15:0] mk_m,
                               input logic [4:0] c, input logic [3:0] f,
                               input logic [3:0] v, input int l);
      exp_t e;
      e.name = nm; e.sop = s; e.pos = p; e.mask = mk_m;
      e.cnt = c; e.first = f; e.vec = v; e.lat = l; e.t0 = 0;
      return e;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      exp_t e1;
      e1 = mk("guia", 16'hE5AB, 16'hE5AB, 16'h0, 5'd0, 4'd0, 4'd15, 33);

      repeat (3) @(negedge clk);
      chk("rst_vec",  vec, 4'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_tt",   {tt_sop, tt_pos}, 32'h0);
      chk("rst_mm",   {mm_mask, 3'b0, mm_cnt, 4'b0, mm_first}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(0, e1, 1'b0);
`ifdef TT_STOP_ON_MISMATCH_EN
      run(1, mk("row9", 16'h01AB, 16'h03AB, 16'h0200, 5'd1, 4'd9, 4'd9, 21), 1'b0);
`else
      run(1, mk("row9", 16'hE5AB, 16'hE7AB, 16'h0200, 5'd1, 4'd9, 4'd15, 33), 1'b0);
`endif
      run(0, mk("restart", 16'hE5AB, 16'hE5AB, 16'h0, 5'd0, 4'd0, 4'd15, 33), 1'b1);

      @(negedge clk);
      q3.push_back(mk("parity", 16'h6996, 16'h6996, 16'h0, 5'd0, 4'd0, 4'd15, 65));
      q3[0].t0 = cyc;
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      for (int i = 0; i < 200 && q3.size() != 0; i++) @(negedge clk);
      if (q3.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL parity_timeout: got no done expected done");
         q3.delete();
      end

      @(negedge clk);
      mode = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 100 && vec != 4'd7; i++) @(negedge clk);
      chk("abort_row7", vec, 4'd7);
      rst_n = 1'b0;
      #1;
      chk("abort_vec",  vec, 4'd0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_tt",   {tt_sop, tt_pos}, 32'h0);
      chk("abort_mm",   {mm_mask, 3'b0, mm_cnt, 4'b0, mm_first}, 32'h0);
      repeat (40) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run(0, mk("post_rst", 16'hE5AB, 16'hE5AB, 16'h0, 5'd0, 4'd0, 4'd15, 33), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
